// File: rtl/systolic_array_controller.sv
// Sequencer for one weight-stationary pass: weight load, ifmap streaming with stalls, drain.
// Optional feature macro: PERF_CNT_EN (16-bit saturating stall counter on stall_cnt).
module systolic_array_controller #(
  parameter int unsigned ARRAY_HEIGHT = 4,
  parameter int unsigned ARRAY_WIDTH  = 4,
  parameter int unsigned OUT_LATENCY  = ARRAY_HEIGHT + ARRAY_WIDTH - 1,
  parameter int unsigned CNT_WIDTH    = 8,
  localparam int unsigned ROW_W = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    num_vec,
  output logic                    busy,
  output logic                    done,
  output logic                    weight_en,
  output logic [ARRAY_HEIGHT-1:0] weight_wen,
  output logic [ROW_W-1:0]        weight_row,
  output logic                    en,
  input  logic                    ifmap_valid,
  output logic                    ifmap_pop,
  output logic                    ofmap_valid,
  output logic [15:0]             stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_FIN
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   num_vec_q, num_vec_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [CNT_WIDTH-1:0]   in_cnt_q, in_cnt_d;
  logic [CNT_WIDTH-1:0]   out_cnt_q, out_cnt_d;
  logic [OUT_LATENCY-1:0] line_q, line_d;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      num_vec_q <= '0;
      row_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      num_vec_q <= num_vec_d;
      row_q     <= row_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      line_q    <= line_d;
    end
  end

  // Next-state logic and output decode
  always_comb begin
    state_d     = state_q;
    num_vec_d   = num_vec_q;
    row_d       = row_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    line_d      = line_q;
    busy        = (state_q != S_IDLE);
    done        = 1'b0;
    weight_en   = 1'b0;
    weight_wen  = '0;
    weight_row  = '0;
    en          = 1'b0;
    ifmap_pop   = 1'b0;
    ofmap_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_vec_d = num_vec;
          row_d     = '0;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          line_d    = '0;
          state_d   = (num_vec == '0) ? S_FIN : S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        weight_en  = 1'b1;
        weight_wen = ARRAY_HEIGHT'(1) << row_q;
        weight_row = row_q;
        row_d      = row_q + ROW_W'(1);
        if (row_q == ROW_W'(ARRAY_HEIGHT - 1)) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        weight_en = 1'b1;
        en        = ifmap_valid;
        ifmap_pop = ifmap_valid;
        if (ifmap_valid) begin
          in_cnt_d = in_cnt_q + CNT_WIDTH'(1);
          if (in_cnt_d == num_vec_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        weight_en = 1'b1;
        en        = 1'b1;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Valid tracking advances in lockstep with the array, so stalls keep results aligned
    ofmap_valid = en & line_q[OUT_LATENCY-1];
    if (en) begin
      line_d = {line_q[OUT_LATENCY-2:0], ifmap_pop};
    end
    if (ofmap_valid) begin
      out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
      if ((state_q == S_DRAIN) && (out_cnt_d == num_vec_q)) begin
        state_d = S_FIN;
      end
    end
  end

`ifdef PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of starved STREAM cycles; held after done until next start
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == S_IDLE) && start) begin
      stall_cnt_d = '0;
    end else if ((state_q == S_STREAM) && !ifmap_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule
